// File: rtl/tlp_xcvr_pkg.sv
// tlp_xcvr_pkg: action, error-code and TLP header types shared by the
// root-port receiver and the FPGA->CPU transmitter.
package tlp_xcvr_pkg;

  localparam int CHAN_NBITS = 4;

  localparam logic [7:0] FMT_MRD32 = 8'h00;
  localparam logic [7:0] FMT_MWR32 = 8'h40;

  typedef logic [CHAN_NBITS-1:0] Channel;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_READ  = 2'd1,
    ACT_WRITE = 2'd2,
    ACT_ERROR = 2'd3
  } ActionType;

  typedef enum logic [3:0] {
    ERR_NONE = 4'd0,
    ERR_TYPE = 4'd1,
    ERR_LEN  = 4'd2,
    ERR_BE   = 4'd3,
    ERR_SOP  = 4'd4
  } ErrorCode;

  typedef struct packed {
    logic [15:0] reqID;
    logic [7:0]  tag;
    Channel      chan;
  } RegRead;

  typedef struct packed {
    Channel      chan;
    logic [31:0] data;
  } RegWrite;

  typedef struct packed {
    ActionType   typ;
    logic [15:0] reqID;
    logic [7:0]  tag;
    Channel      chan;
    logic [31:0] data;
  } Action;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [4:0]  typ;
    logic [13:0] attr;
    logic [9:0]  length;
  } TlpDw0;

  typedef struct packed {
    logic [15:0] reqID;
    logic [7:0]  tag;
    logic [3:0]  lastBE;
    logic [3:0]  firstBE;
  } TlpDw1;

  typedef struct packed {
    TlpDw1 dw1;
    TlpDw0 dw0;
  } TlpHdr;

  function automatic Action mkRead(input RegRead r);
    Action a;
    a = '0;
    a.typ = ACT_READ;
    a.reqID = r.reqID;
    a.tag = r.tag;
    a.chan = r.chan;
    return a;
  endfunction

  function automatic Action mkWrite(input RegWrite w);
    Action a;
    a = '0;
    a.typ = ACT_WRITE;
    a.chan = w.chan;
    a.data = w.data;
    return a;
  endfunction

  function automatic Action mkError(input ErrorCode e);
    Action a;
    a = '0;
    a.typ = ACT_ERROR;
    a.data = {28'd0, e};
    return a;
  endfunction

  // First failing header check wins: type, then length, then byte enables.
  function automatic ErrorCode hdrCheck(input TlpHdr h);
    logic [7:0] ft;
    ft = {h.dw0.fmt, h.dw0.typ};
    if (ft != FMT_MRD32 && ft != FMT_MWR32) return ERR_TYPE;
    if (h.dw0.length != 10'd1) return ERR_LEN;
    if (h.dw1.firstBE != 4'hF) return ERR_BE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/tlp_recv.sv
// tlp_recv: 64-bit Avalon-ST RX TLP parser producing register Actions.
// Define TLP_RECV_ERRCODE_EN to report malformed TLPs as ACT_ERROR.
module tlp_recv
  import tlp_xcvr_pkg::*;
#(
  parameter int REG_BAR = 0
) (
  input  logic        pcieClk_in,
  input  logic        pcieRst_in,
  input  logic [63:0] rxData_in,
  input  logic        rxValid_in,
  output logic        rxReady_out,
  input  logic        rxSOP_in,
  input  logic        rxEOP_in,
  input  logic [7:0]  rxBarHit_in,
  output Action       actData_out,
  output logic        actValid_out,
  input  logic        actReady_in,
  output logic [15:0] dropCount_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR1,
    S_DATA,
    S_DRAIN
  } State;

  State        state, nState;
  Action       actQ, nAct;
  logic        actValid, emit;
  logic [15:0] dropCount;
  logic [16:0] dropSum;
  logic [1:0]  dropInc;
  logic        loadHdr, restart;
  logic [15:0] reqIdQ;
  logic [7:0]  tagQ;
  logic        isRdQ, barOkQ;
  ErrorCode    hdrErrQ;
  ErrorCode    errQ, nErr;
  logic        dropQ, nDrop;
  Channel      chanQ, chan;
  logic        fin, finDrop;
  ErrorCode    finErr;
  TlpHdr       rxHdr;
  logic [31:0] addr;
  logic        rxFire;
  logic        unusedBits;

  assign rxHdr = TlpHdr'(rxData_in);
  assign addr = rxData_in[31:0];
  assign chan = addr[CHAN_NBITS+1:2];
  assign rxReady_out = !actValid && !pcieRst_in;
  assign rxFire = rxValid_in && rxReady_out;
  assign actData_out = actQ;
  assign actValid_out = actValid;
  assign dropCount_out = dropCount;
  assign dropSum = {1'b0, dropCount} + 17'(dropInc);
  assign unusedBits = ^{rxHdr.dw0.attr, rxHdr.dw1.lastBE, rxBarHit_in};

  always_comb begin
    nState = state;
    nAct = actQ;
    emit = 1'b0;
    dropInc = 2'd0;
    loadHdr = 1'b0;
    restart = 1'b0;
    nErr = errQ;
    nDrop = dropQ;
    fin = 1'b0;
    finDrop = 1'b0;
    finErr = ERR_NONE;
    if (rxFire) begin
      unique case (state)
        S_IDLE: begin
          if (rxSOP_in && !rxEOP_in) begin
            loadHdr = 1'b1;
            nState = S_HDR1;
          end else begin
            dropInc = 2'd1;
          end
        end
        S_HDR1: begin
          if (rxSOP_in) begin
            fin = 1'b1;
            finDrop = !barOkQ;
            finErr = (hdrErrQ != ERR_NONE) ? hdrErrQ : ERR_SOP;
            restart = 1'b1;
          end else if (!barOkQ || hdrErrQ != ERR_NONE) begin
            nDrop = !barOkQ;
            nErr = hdrErrQ;
            if (rxEOP_in) begin
              fin = 1'b1;
              finDrop = !barOkQ;
              finErr = hdrErrQ;
              nState = S_IDLE;
            end else begin
              nState = S_DRAIN;
            end
          end else if (isRdQ || addr[2]) begin
            if (rxEOP_in) begin
              emit = 1'b1;
              nState = S_IDLE;
              nAct = isRdQ
                ? mkRead(RegRead'{reqID: reqIdQ, tag: tagQ, chan: chan})
                : mkWrite(RegWrite'{chan: chan, data: rxData_in[63:32]});
            end else begin
              nDrop = 1'b1;
              nState = S_DRAIN;
            end
          end else if (rxEOP_in) begin
            fin = 1'b1;
            finDrop = 1'b1;
            nState = S_IDLE;
          end else begin
            nState = S_DATA;
          end
        end
        S_DATA: begin
          if (rxSOP_in) begin
            fin = 1'b1;
            finErr = ERR_SOP;
            restart = 1'b1;
          end else if (rxEOP_in) begin
            emit = 1'b1;
            nState = S_IDLE;
            nAct = mkWrite(RegWrite'{chan: chanQ, data: rxData_in[31:0]});
          end else begin
            nDrop = 1'b1;
            nState = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (rxSOP_in || rxEOP_in) begin
            fin = 1'b1;
            finDrop = dropQ;
            finErr = (errQ != ERR_NONE) ? errQ : ERR_SOP;
            restart = rxSOP_in;
            nState = S_IDLE;
          end
        end
      endcase
      // Close out the packet being abandoned: count it or report it.
      if (fin) begin
        if (finDrop || finErr == ERR_NONE) begin
          dropInc = dropInc + 2'd1;
        end else begin
`ifdef TLP_RECV_ERRCODE_EN
          emit = 1'b1;
          nAct = mkError(finErr);
`else
          dropInc = dropInc + 2'd1;
`endif
        end
      end
      if (restart) begin
        if (rxEOP_in) begin
          dropInc = dropInc + 2'd1;
          nState = S_IDLE;
        end else begin
          loadHdr = 1'b1;
          nState = S_HDR1;
        end
      end
    end
  end

  always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
    if (pcieRst_in) begin
      state <= S_IDLE;
      actQ <= '0;
      actValid <= 1'b0;
      dropCount <= '0;
      reqIdQ <= '0;
      tagQ <= '0;
      isRdQ <= 1'b0;
      barOkQ <= 1'b0;
      hdrErrQ <= ERR_NONE;
      errQ <= ERR_NONE;
      dropQ <= 1'b0;
      chanQ <= '0;
    end else begin
      state <= nState;
      if (emit) begin
        actQ <= nAct;
        actValid <= 1'b1;
      end else if (actValid && actReady_in) begin
        actValid <= 1'b0;
      end
      dropCount <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      if (loadHdr) begin
        reqIdQ <= rxHdr.dw1.reqID;
        tagQ <= rxHdr.dw1.tag;
        isRdQ <= ({rxHdr.dw0.fmt, rxHdr.dw0.typ} == FMT_MRD32);
        barOkQ <= rxBarHit_in[REG_BAR];
        hdrErrQ <= hdrCheck(rxHdr);
        errQ <= ERR_NONE;
        dropQ <= 1'b0;
      end else begin
        errQ <= nErr;
        dropQ <= nDrop;
      end
      if (rxFire && state == S_HDR1) chanQ <= chan;
    end
  end

endmodule
